instruc_loader: RTL and testbench

Receive-side counterpart of the instruction TX buffer. Takes bytes from the UART receiver (one per rx_done_tick) and packs them MSB-first into 32-bit instruction words. Writes each complete word into instruction memory at sequential byte addresses. Stops on a halt word or when the memory window is full, then flags load completion to the debug unit / pipeline start logic.

---
 rtl/instruc_loader_pkg.sv | 21 ++
 rtl/instruc_loader_byte_packer.sv | 55 +++++
 rtl/instruc_loader.sv | 149 ++++++++++++++
 tb/tb_instruc_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruc_loader_pkg.sv
// -----------------------------------------------------------------------------
// instruc_loader_pkg
// Constants and state encoding shared by the instruction loader and the
// instruction TX buffer: byte/word widths, halt marker and FSM states.
// -----------------------------------------------------------------------------
package instruc_loader_pkg;

   localparam int unsigned NB_BYTE        = 8;
   localparam int unsigned NB_INST        = 32;
   localparam int unsigned BYTES_PER_INST = NB_INST / NB_BYTE;
   localparam int unsigned IDX_W          = $clog2(BYTES_PER_INST);

   localparam logic [NB_INST-1:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRecv = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/instruc_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// instruc_loader_byte_packer
// Packs bytes MSB-first into an instruction word.
//   clk, reset : clock, asynchronous active-high reset
//   flush_i    : discard any partially assembled word
//   valid_i    : byte_i is accepted this cycle
//   byte_i     : incoming byte
//   word_o     : word formed by the stored bytes plus byte_i (valid with done_o)
//   done_o     : this cycle's byte completes a word
// -----------------------------------------------------------------------------
module instruc_loader_byte_packer
   import instruc_loader_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               flush_i,
   input  logic               valid_i,
   input  logic [NB_BYTE-1:0] byte_i,
   output logic [NB_INST-1:0] word_o,
   output logic               done_o
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BYTES_PER_INST - 1);

   // Only the leading bytes are stored; the final byte is taken straight
   // from the input so the word is available in the completing cycle.
   logic [NB_INST-NB_BYTE-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]           idx_q, idx_d;

   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      if (flush_i) begin
         shift_d = '0;
         idx_d   = '0;
      end else if (valid_i) begin
         shift_d = {shift_q[NB_INST-2*NB_BYTE-1:0], byte_i};
         idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

   assign word_o = {shift_q, byte_i};
   assign done_o = valid_i && !flush_i && (idx_q == LastIdx);

endmodule

// File: rtl/instruc_loader.sv
// -----------------------------------------------------------------------------
// instruc_loader
// Assembles UART bytes into 32-bit instructions and writes them to sequential
// instruction-memory byte addresses until a halt word or a full window.
//   clk, reset   : clock, asynchronous active-high reset
//   rx_done_tick : strobe, rx_data valid
//   rx_data      : received byte
//   i_clear      : strobe, restart a load from address 0
//   o_wr_en      : one-cycle memory write strobe
//   o_wr_addr    : write address (held between writes)
//   o_wr_data    : assembled instruction (held between writes)
//   o_word_count : words written in the current load (saturating)
//   o_load_done  : load finished
//   o_err        : sticky, byte dropped or partial word timed out
// -----------------------------------------------------------------------------
module instruc_loader
   import instruc_loader_pkg::*;
#(
   parameter int unsigned NB_ADDR   = 32,
   parameter int unsigned MAX_WORDS = 60,
   parameter int unsigned ADDR_STEP = 4,
   parameter int unsigned TIMEOUT   = 1_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_done_tick,
   input  logic [NB_BYTE-1:0] rx_data,
   input  logic               i_clear,
   output logic               o_wr_en,
   output logic [NB_ADDR-1:0] o_wr_addr,
   output logic [NB_INST-1:0] o_wr_data,
   output logic [7:0]         o_word_count,
   output logic               o_load_done,
   output logic               o_err
);

   localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_e               state_q, state_d;
   logic [NB_ADDR-1:0]   addr_q, addr_d;
   logic [7:0]           count_q, count_d;
   logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
   logic                 err_q, err_d;
   logic                 wr_en_q, wr_en_d;
   logic [NB_ADDR-1:0]   wr_addr_q, wr_addr_d;
   logic [NB_INST-1:0]   wr_data_q, wr_data_d;

   logic                 accept;
   logic                 flush;
   logic [NB_INST-1:0]   packed_word;
   logic                 word_done;

   // Clear wins over a simultaneous byte, and bytes are never taken in DONE.
   assign accept = rx_done_tick && !i_clear && (state_q != StDone);

   instruc_loader_byte_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .valid_i (accept),
      .byte_i  (rx_data),
      .word_o  (packed_word),
      .done_o  (word_done)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      to_cnt_d  = '0;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      flush     = 1'b0;

      if (i_clear) begin
         state_d = StIdle;
         addr_d  = '0;
         count_d = '0;
         err_d   = 1'b0;
         flush   = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) state_d = StRecv;
            end
            StRecv: begin
               if (accept) begin
                  if (word_done) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = addr_q;
                     wr_data_d = packed_word;
                     addr_d    = addr_q + NB_ADDR'(ADDR_STEP);
                     count_d   = (count_q >= 8'(MAX_WORDS)) ? count_q : count_q + 8'd1;
                     // count_q is the pre-write count, so MAX_WORDS-1 means this
                     // write fills the window.
                     if (packed_word == HALT_WORD || count_q >= 8'(MAX_WORDS - 1)) begin
                        state_d = StDone;
                     end else begin
                        state_d = StIdle;
                     end
                  end
               end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                  flush   = 1'b1;
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (rx_done_tick) err_d = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         count_q   <= '0;
         to_cnt_q  <= '0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         to_cnt_q  <= to_cnt_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data    = wr_data_q;
   assign o_word_count = count_q;
   assign o_load_done  = (state_q == StDone);
   assign o_err        = err_q;

endmodule

// File: tb/tb_instruc_loader.sv
// -----------------------------------------------------------------------------
// tb_instruc_loader
// Directed and randomized byte streams against a transaction-level model of
// the loader (byte queue, word count, done and error flags).
// -----------------------------------------------------------------------------
module tb_instruc_loader;

   localparam int unsigned TO   = 16;
   localparam int unsigned MAXW = 60;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_done_tick;
   logic [7:0]  rx_data;
   logic        i_clear;
   logic        o_wr_en;
   logic [31:0] o_wr_addr;
   logic [31:0] o_wr_data;
   logic [7:0]  o_word_count;
   logic        o_load_done;
   logic        o_err;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   logic [7:0] m_part[$];
   int         m_count;
   bit         m_done;
   bit         m_err;

   instruc_loader #(
      .NB_ADDR   (32),
      .MAX_WORDS (MAXW),
      .ADDR_STEP (4),
      .TIMEOUT   (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .i_clear      (i_clear),
      .o_wr_en      (o_wr_en),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_word_count (o_word_count),
      .o_load_done  (o_load_done),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      check("word_count", 64'(o_word_count), 64'(m_count));
      check("load_done", 64'(o_load_done), 64'(m_done));
      check("err", 64'(o_err), 64'(m_err));
   endtask

   task automatic model_reset();
      m_part.delete();
      m_count = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
   endtask

   // All driving tasks start and end on a falling edge.
   task automatic send_byte(input logic [7:0] b);
      bit          exp_wr = 1'b0;
      logic [31:0] exp_data = '0;
      logic [31:0] exp_addr = '0;
      if (m_done) begin
         m_err = 1'b1;
      end else begin
         m_part.push_back(b);
         if (m_part.size() == 4) begin
            exp_data = {m_part[0], m_part[1], m_part[2], m_part[3]};
            exp_addr = 32'(m_count * 4);
            exp_wr   = 1'b1;
            m_count++;
            m_part.delete();
            if (exp_data == 32'hFFFF_FFFF || m_count == MAXW) m_done = 1'b1;
         end
      end
      rx_done_tick = 1'b1;
      rx_data      = b;
      @(negedge clk);
      rx_done_tick = 1'b0;
      check("wr_en", 64'(o_wr_en), 64'(exp_wr));
      if (exp_wr) begin
         check("wr_addr", 64'(o_wr_addr), 64'(exp_addr));
         check("wr_data", 64'(o_wr_data), 64'(exp_data));
      end
      check_state();
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("wr_idle", 64'(o_wr_en), 64'd0);
      end
      // A partial word left idle long enough is discarded.
      if (n >= 2 * TO && m_part.size() > 0) begin
         m_part.delete();
         m_err = 1'b1;
      end
      check_state();
   endtask

   task automatic clear(input bit with_byte, input logic [7:0] b);
      i_clear      = 1'b1;
      rx_done_tick = with_byte;
      rx_data      = b;
      @(negedge clk);
      i_clear      = 1'b0;
      rx_done_tick = 1'b0;
      model_reset();
      check("wr_clear", 64'(o_wr_en), 64'd0);
      check_state();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, 64'(o_wr_en), 64'd0);
      check({tag, "_addr"}, 64'(o_wr_addr), 64'd0);
      check({tag, "_data"}, 64'(o_wr_data), 64'd0);
      check({tag, "_count"}, 64'(o_word_count), 64'd0);
      check({tag, "_done"}, 64'(o_load_done), 64'd0);
      check({tag, "_err"}, 64'(o_err), 64'd0);
   endtask

   initial begin
      logic [31:0] w;
      reset        = 1'b1;
      rx_done_tick = 1'b0;
      rx_data      = '0;
      i_clear      = 1'b0;
      model_reset();
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Two plain words
      send_word(32'h8C01_0004);
      send_word(32'h0000_0020);
      check("t1_count", 64'(o_word_count), 64'd2);
      check("t1_done", 64'(o_load_done), 64'd0);
      idle(2);

      // Halt word terminates; a further byte is dropped with error
      clear(1'b0, 8'h00);
      send_word(32'h2008_0005);
      send_word(32'hFFFF_FFFF);
      check("t2_done", 64'(o_load_done), 64'd1);
      send_byte(8'h12);
      check("t2_err", 64'(o_err), 64'd1);
      idle(2);

      // Full window of random words with random gaps
      clear(1'b0, 8'h00);
      for (int i = 0; i < int'(MAXW); i++) begin
         w = $urandom;
         if (w == 32'hFFFF_FFFF) w = 32'h0;
         for (int j = 3; j >= 0; j--) begin
            send_byte(w[j*8 +: 8]);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
         end
      end
      check("t3_last_addr", 64'(o_wr_addr), 64'd236);
      check("t3_done", 64'(o_load_done), 64'd1);
      send_word(32'h1234_5678);
      check("t3_err", 64'(o_err), 64'd1);
      check("t3_count", 64'(o_word_count), 64'd60);
      idle(2);

      // Partial word timeout
      clear(1'b0, 8'h00);
      send_byte(8'h12);
      send_byte(8'h34);
      idle(3 * TO);
      check("t4_err", 64'(o_err), 64'd1);
      send_word(32'hAABB_CCDD);
      idle(1);

      // Clear concurrent with a byte in DONE
      send_word(32'hFFFF_FFFF);
      check("t5_done_pre", 64'(o_load_done), 64'd1);
      clear(1'b1, 8'h5A);
      check("t5_err", 64'(o_err), 64'd0);
      send_word(32'h0102_0304);
      idle(1);

      // Reset mid-word
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all_zero("midrst");
      @(negedge clk);
      check("midrst_wr_en_hold", 64'(o_wr_en), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      send_word(32'h1122_3344);
      idle(1);

      // Random byte stream rich in 0xFF with occasional clears
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            clear($urandom_range(0, 1) == 1, 8'($urandom));
         end else begin
            send_byte(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 5));
         end
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
